// File: rtl/tree_pkg.sv
// tree_pkg: shared widths, bank state and operand type for the tree adder operand path
package tree_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_OPS = 32;
  localparam int IDX_W = $clog2(NUM_OPS);
  typedef enum logic {BANK_FILL, BANK_FULL} bank_state_e;
  typedef logic signed [DATA_W-1:0] operand_t;
endpackage

// File: rtl/tree_operand_loader_if.sv
// tree_operand_loader_if: sample-in / frame-out handshake bundle
interface tree_operand_loader_if;
  import tree_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_last;
  operand_t in_data;
  logic out_valid;
  logic out_ready;
  logic [NUM_OPS*DATA_W-1:0] out_data;
  logic [IDX_W:0] out_count;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/tree_operand_bank.sv
// tree_operand_bank: one frame buffer with write index, count, fill/full state and zero-masked read port
module tree_operand_bank
  import tree_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  operand_t                  wr_data,
  input  logic                      wr_last,
  input  logic                      rel,
  output bank_state_e               st,
  output logic [NUM_OPS*DATA_W-1:0] rd_data,
  output logic [IDX_W:0]            rd_count
);
  operand_t mem [NUM_OPS];
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0] cnt;
  logic acc;
  logic close;
  assign acc = wr_en && st == BANK_FILL;
  assign close = acc && (wr_last || idx == IDX_W'(NUM_OPS-1));
  assign rd_count = cnt;
  // cnt is zero outside FULL, so every slot masks itself when nothing is presented
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_slot
    assign rd_data[k*DATA_W +: DATA_W] = cnt > (IDX_W+1)'(k) ? mem[k] : '0;
  end
  // sample storage, no reset needed since unused slots are masked
  always_ff @(posedge clk) if (acc) mem[idx] <= wr_data;
  // fill/full state, write index and frame count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= BANK_FILL;
      idx <= '0;
      cnt <= '0;
    end else if (rel && st == BANK_FULL) begin
      st <= BANK_FILL;
      idx <= '0;
      cnt <= '0;
    end else if (close) begin
      st <= BANK_FULL;
      cnt <= {1'b0, idx} + 1'b1;
    end else if (acc) idx <= idx + 1'b1;
endmodule

// File: rtl/tree_operand_loader.sv
// tree_operand_loader: packs signed samples into zero-padded frames; define TREE_LOADER_PINGPONG_EN for two banks
module tree_operand_loader
  import tree_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  tree_operand_loader_if.slave bus
);
  logic acc;
  logic rel;
  assign acc = bus.in_valid && bus.in_ready;
  assign rel = bus.out_valid && bus.out_ready;
`ifdef TREE_LOADER_PINGPONG_EN
  bank_state_e st [2];
  logic [NUM_OPS*DATA_W-1:0] data [2];
  logic [IDX_W:0] cnt [2];
  logic psel;
  logic fsel;
  logic rsel;
  // fill the last-used bank while it is open, otherwise the other one
  assign fsel = st[psel] == BANK_FILL ? psel : ~psel;
  assign bus.in_ready = st[fsel] == BANK_FILL;
  assign bus.out_valid = st[rsel] == BANK_FULL;
  assign bus.out_data = data[rsel];
  assign bus.out_count = cnt[rsel];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    tree_operand_bank u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (acc && fsel == 1'(b)),
      .wr_data  (bus.in_data),
      .wr_last  (bus.in_last),
      .rel      (rel && rsel == 1'(b)),
      .st       (st[b]),
      .rd_data  (data[b]),
      .rd_count (cnt[b])
    );
  end
  // banks fill alternately, so presentation simply alternates on each release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      psel <= 1'b0;
      rsel <= 1'b0;
    end else begin
      psel <= fsel;
      rsel <= rsel ^ rel;
    end
`else
  bank_state_e st;
  assign bus.in_ready = st == BANK_FILL;
  assign bus.out_valid = st == BANK_FULL;
  tree_operand_bank u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (acc),
    .wr_data  (bus.in_data),
    .wr_last  (bus.in_last),
    .rel      (rel),
    .st       (st),
    .rd_data  (bus.out_data),
    .rd_count (bus.out_count)
  );
`endif
endmodule

// File: tb/tb_tree_operand_loader.sv
// tb_tree_operand_loader: frame-queue model plus directed vectors for the operand loader
module tb_tree_operand_loader;
  import tree_pkg::*;
`ifdef TREE_LOADER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int FW = NUM_OPS*DATA_W;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int waits = 0;
  int n_rel = 0;
  logic [FW-1:0] q_data[$];
  int q_cnt[$];
  logic [FW-1:0] cur_data;
  int cur_n;
  bit rdy;
  always #5 clk = ~clk;
  tree_operand_loader_if bus();
  tree_operand_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // model: pending frames are a queue, one slot per bank; the partial frame is built zero-padded
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q_data.delete();
      q_cnt.delete();
      cur_data = '0;
      cur_n = 0;
    end else begin
      rdy = q_cnt.size() < NB;
      if (q_cnt.size() > 0 && bus.out_ready) begin
        void'(q_data.pop_front());
        void'(q_cnt.pop_front());
        n_rel++;
      end
      if (bus.in_valid && rdy) begin
        cur_data[cur_n*DATA_W +: DATA_W] = bus.in_data;
        cur_n++;
        if (bus.in_last || cur_n == NUM_OPS) begin
          q_data.push_back(cur_data);
          q_cnt.push_back(cur_n);
          cur_data = '0;
          cur_n = 0;
        end
      end
    end
  end

  // compare DUT against the model every cycle out of reset
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", FW'(bus.in_ready), FW'(q_cnt.size() < NB));
      chk("out_valid", FW'(bus.out_valid), FW'(q_cnt.size() > 0));
      if (q_cnt.size() > 0) begin
        chk("out_count", FW'(bus.out_count), FW'(q_cnt[0]));
        chk("out_data", bus.out_data, q_data[0]);
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    while (bus.in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    waits += t;
    if (t >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic send_seq(input int n, input int base);
    for (int i = 0; i < n; i++) send(DATA_W'(base + i), 1'b0);
  endtask

  task automatic send_const(input int n, input logic [DATA_W-1:0] v);
    for (int i = 0; i < n; i++) send(v, 1'b0);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.out_valid && t < 100);
    chk("drain", FW'(bus.out_valid), FW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int r0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", FW'(bus.out_valid), FW'(0));
    chk("rst_out_count", FW'(bus.out_count), FW'(0));
    chk("rst_out_data", bus.out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", FW'(bus.in_ready), FW'(1));
    // full frame 1..32
    bus.out_ready = 1'b1;
    send_seq(32, 1);
    @(negedge clk);
    chk("full_valid", FW'(bus.out_valid), FW'(1));
    chk("full_count", FW'(bus.out_count), FW'(32));
    chk("full_slot0", FW'(bus.out_data[0 +: DATA_W]), FW'(16'h0001));
    chk("full_slot31", FW'(bus.out_data[31*DATA_W +: DATA_W]), FW'(16'h0020));
    wait_idle();
    // stale 0x7FFF frames in every bank, then a short frame
    send_const(32*NB, 16'h7FFF);
    wait_idle();
    bus.out_ready = 1'b0;
    send(16'hFFFB, 1'b0);
    send(16'h0007, 1'b0);
    send(16'hFFFD, 1'b1);
    @(negedge clk);
    chk("early_count", FW'(bus.out_count), FW'(3));
    chk("early_slot0", FW'(bus.out_data[0 +: DATA_W]), FW'(16'hFFFB));
    chk("early_slot1", FW'(bus.out_data[DATA_W +: DATA_W]), FW'(16'h0007));
    chk("early_slot2", FW'(bus.out_data[2*DATA_W +: DATA_W]), FW'(16'hFFFD));
    chk("early_pad", bus.out_data >> (3*DATA_W), '0);
    // backpressure
    if (NB == 2) send_seq(32, 200);
    else begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'h1234;
      repeat (10) @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp_in_ready", FW'(bus.in_ready), FW'(0));
    chk("bp_count", FW'(bus.out_count), FW'(3));
    chk("bp_slot2", FW'(bus.out_data[2*DATA_W +: DATA_W]), FW'(16'hFFFD));
    bus.out_ready = 1'b1;
    wait_idle();
    // back-to-back frames
    w0 = waits;
    r0 = n_rel;
    send_seq(128, 1000);
    wait_idle();
    chk("b2b_bubbles", FW'(waits - w0), FW'(NB == 2 ? 0 : 3));
    chk("b2b_frames", FW'(n_rel - r0), FW'(4));
    // single-sample frame
    bus.out_ready = 1'b0;
    send(16'h8000, 1'b1);
    @(negedge clk);
    chk("one_count", FW'(bus.out_count), FW'(1));
    chk("one_data", bus.out_data, FW'(16'h8000));
    bus.out_ready = 1'b1;
    wait_idle();
    // reset in the middle of a frame
    send_seq(17, 50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", FW'(bus.out_valid), FW'(0));
    chk("mid_rst_count", FW'(bus.out_count), FW'(0));
    chk("mid_rst_ready", FW'(bus.in_ready), FW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    send_seq(32, 100);
    @(negedge clk);
    chk("post_rst_count", FW'(bus.out_count), FW'(32));
    chk("post_rst_slot0", FW'(bus.out_data[0 +: DATA_W]), FW'(16'd100));
    chk("post_rst_slot31", FW'(bus.out_data[31*DATA_W +: DATA_W]), FW'(16'd131));
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
